pulse_stretcher: RTL

- Converts single-cycle event pulses into human-visible fixed-width pulses. Typical sources are the button debounce/one-shot chain and counter terminal ticks.
- This is the reverse direction of the pulse-shortening stage: it widens short events rather than narrowing levels.
- Events arriving while a stretched pulse is in progress are queued and replayed with a minimum low gap, so no event is visually merged.
- Sits between event sources and LEDs, buzzers or 7-segment blink logic on the 50 MHz board clock.

---
 rtl/pulse_stretcher_if.sv | 33 +++
 rtl/pulse_stretcher.sv | 130 +++++++++++++
 2 files changed

// File: rtl/pulse_stretcher_if.sv
// rtl/pulse_stretcher_if.sv - event/status bundle between event sources and the pulse stretcher
interface pulse_stretcher_if #(
  parameter int MAX_PENDING = 7
);
  localparam int PW = $clog2(MAX_PENDING + 1);

  logic          pulse_in;
  logic          clear;
  logic          pulse_out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  // Event source side: raises events and aborts, observes the stretched output.
  modport master (
    output pulse_in,
    output clear,
    input  pulse_out,
    input  busy,
    input  pending,
    input  overflow
  );

  // Stretcher side.
  modport slave (
    input  pulse_in,
    input  clear,
    output pulse_out,
    output busy,
    output pending,
    output overflow
  );
endinterface

// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - widens single-cycle events into fixed-width pulses with queued replay
module pulse_stretcher #(
  parameter int HIGH_CYCLES = 25000000,
  parameter int GAP_CYCLES  = 12500000,
  parameter int MAX_PENDING = 7
) (
  input logic              clk,
  input logic              rst,
  pulse_stretcher_if.slave bus
);
  localparam int PW    = $clog2(MAX_PENDING + 1);
  localparam int T_MAX = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
  // A single-cycle high and gap would give a zero-width timer; keep at least one bit.
  localparam int CW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [CW-1:0] HIGH_LOAD = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PENDING);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] timer_q, timer_d;
  logic [PW-1:0] pend_q, pend_d;
  logic          ov_q, ov_d;
  logic          out_q;
  logic          busy_q;
  logic          ev_inc;
  logic          ev_dec;
  logic          timer_zero;

  assign timer_zero = (timer_q == '0);

  // Next-state, timer and pending-queue decisions for this cycle.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pend_d  = pend_q;
    ov_d    = 1'b0;
    ev_inc  = 1'b0;
    ev_dec  = 1'b0;

    if (bus.clear) begin
      // Abort wins over everything; the same-cycle event is thrown away.
      state_d = ST_IDLE;
      timer_d = '0;
      pend_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.pulse_in) begin
            state_d = ST_HIGH;
            timer_d = HIGH_LOAD;
          end
        end

        ST_HIGH: begin
          ev_inc = bus.pulse_in;
          if (timer_zero) begin
            state_d = ST_GAP;
            timer_d = GAP_LOAD;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end

        ST_GAP: begin
          ev_inc = bus.pulse_in;
          if (timer_zero) begin
            // An event arriving on this very cycle counts towards the replay decision.
            if ((pend_q != '0) || bus.pulse_in) begin
              state_d = ST_HIGH;
              timer_d = HIGH_LOAD;
              ev_dec  = 1'b1;
            end else begin
              state_d = ST_IDLE;
              timer_d = '0;
            end
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end

        default: begin
          state_d = ST_IDLE;
          timer_d = '0;
          pend_d  = '0;
        end
      endcase

      // A simultaneous enqueue and replay cancel out, so nothing is dropped even when full.
      if (ev_inc && !ev_dec) begin
        if (pend_q == PEND_MAX) begin
          ov_d = 1'b1;
        end else begin
          pend_d = pend_q + 1'b1;
        end
      end else if (ev_dec && !ev_inc) begin
        pend_d = pend_q - 1'b1;
      end
    end
  end

  // State and registered outputs; outputs follow the next state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      pend_q  <= '0;
      ov_q    <= 1'b0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      ov_q    <= ov_d;
      out_q   <= (state_d == ST_HIGH);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign bus.pulse_out = out_q;
  assign bus.busy      = busy_q;
  assign bus.pending   = pend_q;
  assign bus.overflow  = ov_q;

endmodule
